serial_word_assembler: RTL and testbench
========================================

Name: serial_word_assembler

Overview:
- Upstream feeder of the RISC-V wrapper.
- Receives 8N1 UART bytes on a single RX line and packs four bytes into one 32-bit word.
- Presents each completed word with a one-cycle ready pulse, matching the wrapper's word-input/ready-pulse interface.
- Drops words while the processor is busy, and reports framing, timeout and overrun conditions.

Parameters:
- CLKS_PER_BIT, 434, i_Clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- TIMEOUT_CLKS, 17360, idle cycles after a byte before a partial word is discarded (40 bit times).

Ports:
- i_Clk  input  1  single clock for the whole block.
- i_Rstn  input  1  reset, synchronous, active-low.
- i_rx  input  1  asynchronous UART RX line, idle high.
- i_proc_busy  input  1  processor running; words completed while high are dropped.
- i_clr_err  input  1  one-cycle pulse that clears all sticky flags.
- o_word  output  32  last emitted word; byte 0 (first received) in [7:0], byte 3 in [31:24].
- o_number_ready  output  1  one-cycle pulse, o_word valid.
- o_word_count  output  8  emitted-word counter, wraps 255->0.
- o_frame_err  output  1  sticky: stop bit sampled low (or parity bad, see option).
- o_timeout  output  1  sticky: partial word discarded by timeout.
- o_overrun  output  1  sticky: word completed while i_proc_busy high.
- dbg_rx_state  output  3  current RX FSM state encoding.

Behaviour:
Reset (i_Rstn low at a rising edge):
- All outputs go to 0, except the sync flops, which go to 1.
- RX FSM goes to IDLE; byte index 0; timeout counter 0.
- Reset mid-byte or mid-word discards all partial data. Reception restarts at the next high->low edge.

Input synchronisation:
- i_rx passes through a 2-flop synchroniser (reset value 1).
- All sampling uses the synchronised signal rx_s.

RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: a falling edge of rx_s (previous 1, current 0) -> START, bit counter cleared.
- START: at CLKS_PER_BIT/2 (integer division), sample rx_s.
  - 1 -> IDLE (glitch, no error).
  - 0 -> DATA.
- DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into the byte register. After bit 7 -> PARITY if enabled, else STOP.
- STOP: sample after CLKS_PER_BIT.
  - 1 -> byte accepted.
  - 0 -> o_frame_err set, byte and partial word discarded, byte index 0.
  - Either way -> IDLE on the same cycle.
  - A line held low (break) produces no further bytes until a new falling edge.

Word assembly:
- An accepted byte is written to o_word-staging bits [8k+7:8k], where k is the byte index; then k increments.
- When the 4th byte is accepted (k=3), on the next cycle:
  - i_proc_busy low: o_word <= staging, o_number_ready=1 for exactly one cycle, o_word_count += 1, k <= 0.
  - i_proc_busy high: no pulse, o_word unchanged, o_overrun set, k <= 0.
- o_word holds its value between emissions.
- Latency: the o_number_ready pulse comes 1 cycle after the stop-bit sample of byte 3. The 2-flop synchroniser adds a further 2 cycles from the pin.

Timeout:
- The counter runs only while k != 0 and the FSM is in IDLE; it is cleared on every accepted byte and whenever k = 0.
- Reaching TIMEOUT_CLKS sets o_timeout, sets k <= 0 and clears staging.
- If byte acceptance and timeout expiry fall on the same cycle, acceptance wins: the counter clears and no timeout is recorded.

Sticky flags:
- Cleared by i_clr_err. If a set condition coincides with i_clr_err, set wins.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - FSM includes the PARITY state: one bit sampled CLKS_PER_BIT after bit 7.
  - Even parity is required (XOR of 8 data bits and the parity bit = 0).
  - Mismatch sets o_frame_err and discards the byte and partial word, exactly like a bad stop bit; the STOP state is still traversed.
- Undefined:
  - 8N1 only; no PARITY state.
  - dbg_rx_state never shows the PARITY encoding.

Decomposition:
- Shared package serial_pkg:
  - RX state enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - Default CLKS_PER_BIT and TIMEOUT_CLKS constants.
  - Byte-index width constant.
- Sub-module uart_rx_byte: synchroniser, bit-timing counter, RX FSM, optional parity. Outputs a byte, a byte_valid pulse, a frame_err pulse and its state.
- The top level holds word assembly, timeout, busy gating, counters and flags.

Test Plan:
- Send bytes 0x78,0x56,0x34,0x12, i_proc_busy=0 -> o_word=0x12345678, one o_number_ready pulse, o_word_count=1, no flags.
- Send 8 words back-to-back -> 8 pulses, o_word_count=8, each word correct, no timeout.
- Send 2 bytes, idle 20000 cycles, then send 4 bytes 0xAA,0xBB,0xCC,0xDD -> o_timeout=1 and o_word=0xDDCCBBAA; the first 2 bytes do not appear.
- Byte with stop bit 0 as 2nd byte of a word, then 4 good bytes -> o_frame_err=1; the next word is the 4 good bytes only. Pulse i_clr_err -> flag clears.
- 4 bytes with i_proc_busy=1 -> no pulse, o_overrun=1, o_word unchanged, o_word_count unchanged.
- i_Rstn low for 1 cycle during bit 4 of byte 2 -> all outputs 0; the next 4 bytes form a correct word. Also a 1/4-bit low glitch on idle i_rx -> no byte, no error.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared RX state encoding and default timing constants for the serial word assembler.
package serial_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int DEF_TIMEOUT_CLKS = 17360;
   localparam int BYTE_IDX_W       = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised UART byte receiver; 8N1 by default, even parity when SERIAL_PARITY_EN is defined.
module uart_rx_byte
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
   input  logic       i_Clk,
   input  logic       i_Rstn,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output rx_state_t  o_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef SERIAL_PARITY_EN
   localparam rx_state_t AFTER_DATA = S_PARITY;
`else
   localparam rx_state_t AFTER_DATA = S_STOP;
`endif

   logic          r_rx_m, r_rx_s, r_rx_prev;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_par_bad;
   rx_state_t     r_state;
   logic          w_full, w_half;

   always_comb begin
      w_full = r_cnt == CW'(CLKS_PER_BIT - 1);
      w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
   end

   always_ff @(posedge i_Clk)
      if (!i_Rstn) begin
         r_rx_m       <= 1'b1;
         r_rx_s       <= 1'b1;
         r_rx_prev    <= 1'b1;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_state      <= S_IDLE;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         r_rx_m       <= i_rx;
         r_rx_s       <= r_rx_m;
         r_rx_prev    <= r_rx_s;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt     <= '0;
               r_bit     <= '0;
               r_par_bad <= 1'b0;
               if (r_rx_prev && !r_rx_s) r_state <= S_START;
            end
            S_START:
               if (w_half) begin
                  r_cnt   <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_DATA;
               end else r_cnt <= r_cnt + 1'b1;
            S_DATA:
               if (w_full) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7) r_state <= AFTER_DATA;
               end else r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_PARITY_EN
            S_PARITY:
               if (w_full) begin
                  r_cnt     <= '0;
                  r_par_bad <= ^{r_shift, r_rx_s};
                  r_state   <= S_STOP;
               end else r_cnt <= r_cnt + 1'b1;
`endif
            S_STOP:
               if (w_full) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (r_rx_s && !r_par_bad) begin
                     o_byte       <= r_shift;
                     o_byte_valid <= 1'b1;
                  end else o_frame_err <= 1'b1;
               end else r_cnt <= r_cnt + 1'b1;
            default: r_state <= S_IDLE;
         endcase
      end

   assign o_state = r_state;

endmodule

// File: rtl/serial_word_assembler.sv
// serial_word_assembler: packs four UART bytes into a 32-bit word with busy gating, timeout and sticky error flags.
// Optional even parity checking is enabled by defining SERIAL_PARITY_EN.
module serial_word_assembler
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
)(
   input  logic        i_Clk,
   input  logic        i_Rstn,
   input  logic        i_rx,
   input  logic        i_proc_busy,
   input  logic        i_clr_err,
   output logic [31:0] o_word,
   output logic        o_number_ready,
   output logic [7:0]  o_word_count,
   output logic        o_frame_err,
   output logic        o_timeout,
   output logic        o_overrun,
   output logic [2:0]  dbg_rx_state
);

   localparam int TW = $clog2(TIMEOUT_CLKS);

   logic [7:0]            w_byte;
   logic                  w_byte_valid, w_frame_err;
   rx_state_t             w_state;
   logic [BYTE_IDX_W-1:0] r_k;
   logic [23:0]           r_staging;
   logic [TW-1:0]         r_to_cnt;
   logic [31:0]           r_word;
   logic [7:0]            r_cnt;
   logic                  r_ready, r_ferr, r_to, r_ovr;
   logic                  w_last, w_emit, w_ovr_set, w_to_hit;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .i_Clk        (i_Clk),
      .i_Rstn       (i_Rstn),
      .i_rx         (i_rx),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err),
      .o_state      (w_state)
   );

   // acceptance beats timeout expiry on the same cycle
   always_comb begin
      w_last    = w_byte_valid && (&r_k);
      w_emit    = w_last && !i_proc_busy;
      w_ovr_set = w_last && i_proc_busy;
      w_to_hit  = (r_k != '0) && (w_state == S_IDLE) && !w_byte_valid && !w_frame_err &&
                  (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
   end

   always_ff @(posedge i_Clk)
      if (!i_Rstn) begin
         r_k       <= '0;
         r_staging <= '0;
         r_to_cnt  <= '0;
         r_word    <= '0;
         r_cnt     <= '0;
         r_ready   <= 1'b0;
         r_ferr    <= 1'b0;
         r_to      <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_ready  <= w_emit;
         r_ferr   <= w_frame_err | (r_ferr & ~i_clr_err);
         r_to     <= w_to_hit | (r_to & ~i_clr_err);
         r_ovr    <= w_ovr_set | (r_ovr & ~i_clr_err);
         r_to_cnt <= (w_byte_valid || r_k == '0 || w_to_hit) ? '0 :
                     (w_state == S_IDLE) ? r_to_cnt + 1'b1 : r_to_cnt;
         if (w_emit) begin
            r_word <= {w_byte, r_staging};
            r_cnt  <= r_cnt + 1'b1;
         end
         if (w_frame_err || w_to_hit || w_last) begin
            r_k       <= '0;
            r_staging <= '0;
         end else if (w_byte_valid) begin
            r_staging[8*r_k +: 8] <= w_byte;
            r_k                   <= r_k + 1'b1;
         end
      end

   assign o_word         = r_word;
   assign o_number_ready = r_ready;
   assign o_word_count   = r_cnt;
   assign o_frame_err    = r_ferr;
   assign o_timeout      = r_to;
   assign o_overrun      = r_ovr;
   assign dbg_rx_state   = w_state;

endmodule

// File: tb/tb_serial_word_assembler.sv
// tb_serial_word_assembler: table-driven word vectors plus hand sequences for timeout, framing, reset and glitch cases.
module tb_serial_word_assembler;

   localparam int CPB = 8;
   localparam int TO  = 320;

   typedef struct {
      logic [31:0] data;
      logic        busy;
      logic [31:0] exp_word;
      logic [7:0]  exp_cnt;
      logic        exp_ovr;
   } vec_t;

   logic        i_Clk = 1'b0, i_Rstn = 1'b0, i_rx = 1'b1, i_proc_busy = 1'b0, i_clr_err = 1'b0;
   logic [31:0] o_word;
   logic        o_number_ready, o_frame_err, o_timeout, o_overrun;
   logic [7:0]  o_word_count;
   logic [2:0]  dbg_rx_state;
   int          n_vec = 0, n_err = 0;
   logic [31:0] sb[$];
   vec_t        v[10];
   logic [31:0] w8[8];

   always #5 i_Clk = ~i_Clk;

   serial_word_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
      .i_Clk          (i_Clk),
      .i_Rstn         (i_Rstn),
      .i_rx           (i_rx),
      .i_proc_busy    (i_proc_busy),
      .i_clr_err      (i_clr_err),
      .o_word         (o_word),
      .o_number_ready (o_number_ready),
      .o_word_count   (o_word_count),
      .o_frame_err    (o_frame_err),
      .o_timeout      (o_timeout),
      .o_overrun      (o_overrun),
      .dbg_rx_state   (dbg_rx_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   always @(negedge i_Clk)
      if (o_number_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: o_word=%h, no word pending", o_word);
         end else chk("word", o_word, sb.pop_front());
      end

   task automatic hold(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   task automatic send_bit(input logic b);
      i_rx = b;
      hold(CPB);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SERIAL_PARITY_EN
      send_bit(^b);
`endif
      send_bit(stop);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic pulse_clr();
      i_clr_err = 1'b1;
      hold(1);
      i_clr_err = 1'b0;
      hold(1);
   endtask

   initial begin
      w8 = '{32'hA5A55A5A, 32'hFFFFFFFF, 32'h00000000, 32'h01020408,
             32'h80402010, 32'hDEADBEEF, 32'h13579BDF, 32'hF0E1D2C3};
      v[0] = '{32'h12345678, 1'b0, 32'h12345678, 8'd1, 1'b0};
      for (int i = 0; i < 8; i++) v[i+1] = '{w8[i], 1'b0, w8[i], 8'(i + 2), 1'b0};
      v[9] = '{32'hCAFEF00D, 1'b1, 32'hF0E1D2C3, 8'd9, 1'b1};

      hold(3);
      chk("rst_word", o_word, 32'h0);
      chk("rst_cnt", {24'h0, o_word_count}, 32'h0);
      chk("rst_flags", {29'h0, o_frame_err, o_timeout, o_overrun}, 32'h0);
      chk("rst_ready", {31'h0, o_number_ready}, 32'h0);
      chk("rst_state", {29'h0, dbg_rx_state}, 32'h0);
      i_Rstn = 1'b1;
      hold(4);

      for (int i = 0; i < 10; i++) begin
         i_proc_busy = v[i].busy;
         if (!v[i].busy) sb.push_back(v[i].data);
         send_word(v[i].data);
         hold(2);
         chk("vec_word", o_word, v[i].exp_word);
         chk("vec_cnt", {24'h0, o_word_count}, {24'h0, v[i].exp_cnt});
         chk("vec_ovr", {31'h0, o_overrun}, {31'h0, v[i].exp_ovr});
         chk("vec_no_err", {30'h0, o_frame_err, o_timeout}, 32'h0);
         chk("vec_sb", 32'(sb.size()), 32'h0);
      end
      i_proc_busy = 1'b0;

      send_byte(8'h55, 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      i_rx = 1'b0;
      hold(CPB / 2);
      chk("mid_byte_state", {29'h0, dbg_rx_state}, 32'h2);
      i_Rstn = 1'b0;
      hold(1);
      i_Rstn = 1'b1;
      i_rx   = 1'b1;
      chk("mid_rst_word", o_word, 32'h0);
      chk("mid_rst_cnt", {24'h0, o_word_count}, 32'h0);
      chk("mid_rst_flags", {29'h0, o_frame_err, o_timeout, o_overrun}, 32'h0);
      chk("mid_rst_state", {29'h0, dbg_rx_state}, 32'h0);
      hold(2 * CPB);
      sb.push_back(32'h0BADF00D);
      send_word(32'h0BADF00D);
      hold(2);
      chk("post_rst_cnt", {24'h0, o_word_count}, 32'h1);

      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      hold(TO + 80);
      chk("timeout_set", {31'h0, o_timeout}, 32'h1);
      sb.push_back(32'hDDCCBBAA);
      send_word(32'hDDCCBBAA);
      hold(2);
      chk("timeout_word", o_word, 32'hDDCCBBAA);
      chk("timeout_cnt", {24'h0, o_word_count}, 32'h2);
      pulse_clr();
      chk("timeout_clr", {31'h0, o_timeout}, 32'h0);

      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("frame_set", {31'h0, o_frame_err}, 32'h1);
      sb.push_back(32'h11223344);
      send_word(32'h11223344);
      hold(2);
      chk("frame_word", o_word, 32'h11223344);
      chk("frame_cnt", {24'h0, o_word_count}, 32'h3);
      pulse_clr();
      chk("frame_clr", {31'h0, o_frame_err}, 32'h0);

      i_rx = 1'b0;
      hold(CPB / 4);
      i_rx = 1'b1;
      hold(3 * CPB);
      chk("glitch_flags", {29'h0, o_frame_err, o_timeout, o_overrun}, 32'h0);
      chk("glitch_state", {29'h0, dbg_rx_state}, 32'h0);
      chk("glitch_cnt", {24'h0, o_word_count}, 32'h3);
      sb.push_back(32'h89ABCDEF);
      send_word(32'h89ABCDEF);
      hold(2);
      chk("glitch_next_word", o_word, 32'h89ABCDEF);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
